// File: rtl/seg_scan_ctrl.sv
// Multiplexed eight-digit hex seven-segment scanner with bulk and single-digit writes.
// Optional leading-zero blanking is compiled in with SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ld,
  input  logic [31:0] ld_data,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [3:0]  wr_data,
  output logic [2:0]  sel,
  output logic [6:0]  seg,
  output logic        tick,
  output logic        frame
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [2:0]    sel_reg;
  logic          tick_reg;
  logic          frame_reg;
  logic [3:0]    digit_reg [8];
  logic [3:0]    cur_digit;
  logic [6:0]    seg_raw;

  // Scan timing: tick/frame describe the sel value that becomes visible after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      sel_reg   <= '0;
      tick_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end else if (en && (cnt_reg == CNT_LAST)) begin
      cnt_reg   <= '0;
      sel_reg   <= sel_reg + 3'd1;
      tick_reg  <= 1'b1;
      frame_reg <= (sel_reg == 3'd7);
    end else begin
      if (en) cnt_reg <= cnt_reg + CW'(1);
      tick_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end
  end

  // A single-digit write overrides the bulk load for its own digit only.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst)
        digit_reg[i] <= '0;
      else if (wr_en && (wr_addr == 3'(i)))
        digit_reg[i] <= wr_data;
      else if (ld)
        digit_reg[i] <= ld_data[4*i +: 4];
    end
  end

  assign cur_digit = digit_reg[sel_reg];

  always_comb begin
    seg_raw = 7'h00;
    case (cur_digit)
      4'h0: seg_raw = 7'h3F;
      4'h1: seg_raw = 7'h06;
      4'h2: seg_raw = 7'h5B;
      4'h3: seg_raw = 7'h4F;
      4'h4: seg_raw = 7'h66;
      4'h5: seg_raw = 7'h6D;
      4'h6: seg_raw = 7'h7D;
      4'h7: seg_raw = 7'h07;
      4'h8: seg_raw = 7'h7F;
      4'h9: seg_raw = 7'h6F;
      4'hA: seg_raw = 7'h77;
      4'hB: seg_raw = 7'h7C;
      4'hC: seg_raw = 7'h39;
      4'hD: seg_raw = 7'h5E;
      4'hE: seg_raw = 7'h79;
      4'hF: seg_raw = 7'h71;
      default: seg_raw = 7'h00;
    endcase
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  // lz[k]: digits 7..k are all zero; digit 0 is never blanked.
  logic [7:0] lz;
  always_comb begin
    lz    = '0;
    lz[7] = (digit_reg[7] == 4'h0);
    for (int k = 6; k >= 0; k--)
      lz[k] = lz[k+1] && (digit_reg[k] == 4'h0);
  end
  assign seg = ((sel_reg != 3'd0) && lz[sel_reg]) ? 7'h00 : seg_raw;
`else
  assign seg = seg_raw;
`endif

  assign sel   = sel_reg;
  assign tick  = tick_reg;
  assign frame = frame_reg;

endmodule
